uart_rx_deframer: RTL and testbench

//  8N1 UART receiver: LSB-first, no parity. Deframes the serial rx line into bytes.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_deframer.sv | 137 +++++++++++++
 tb/tb_uart_rx_deframer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period helper, data width.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus falling-edge detect.
module uart_rx_sync (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic rx,
   output logic rx_s,
   output logic rx_fall
);

   logic rx_meta;
   logic rx_prev;

   // Idle-high reset values keep a reset from looking like a start edge.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with valid/ready hold register and framing/overrun pulses.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 27_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun_err
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

`ifdef UART_RX_MAJORITY_EN
   localparam int SAMPLE_LAG = 1;
`else
   localparam int SAMPLE_LAG = 0;
`endif

   localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF_BIT - 1 + SAMPLE_LAG);
   localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   logic rx_s;
   logic rx_fall;
   logic sample;

   uart_rx_sync u_sync (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .rx      (rx),
      .rx_s    (rx_s),
      .rx_fall (rx_fall)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] rx_hist;

   // The decision cycle sees mid-1 and mid in the history plus mid+1 live.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) rx_hist <= 2'b11;
      else         rx_hist <= {rx_hist[0], rx_s};
   end

   assign sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
   assign sample = rx_s;
`endif

   uart_state_e          state;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;

   // NOTE: every register here uses <= so all branches read pre-edge values;
   // the later rx_valid <= 1 on a completed byte overrides the handshake clear.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_busy     <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_fall) begin
                  state   <= START;
                  cnt     <= '0;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == START_PT) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  if (!sample) begin
                     state <= DATA;
                  end else begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_PT) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= sample;
                  if (bit_idx == LAST_BIT) state   <= STOP;
                  else                     bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == BIT_PT) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  rx_busy <= 1'b0;
                  if (!sample) begin
                     frame_err <= 1'b1;
                  end else if (!rx_valid || rx_ready) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end else begin
                     overrun_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 27 MHz / 115200 baud (234 clk/bit).
module tb_uart_rx_deframer;

   localparam int CPB  = 234;
   localparam int HALF = 117;

   logic       sys_clk  = 1'b0;
   logic       sys_rst  = 1'b1;
   logic       rx       = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Monitor state: written only by the negedge monitor, read as deltas.
   logic [7:0] got[$];
   int valid_rise   = -1;
   int ferr_cyc     = -1;
   int valid_cycles = 0;
   int ferr_cnt     = 0;
   int ovr_cnt      = 0;
   int busy_rise    = 0;
   int busy_fall    = 0;
   logic valid_q    = 1'b0;
   logic busy_q     = 1'b0;

   // Snapshot bases taken by the stimulus thread.
   int b_got, b_valid, b_ferr, b_ovr, b_brise, b_bfall;

   uart_rx_deframer dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_busy     (rx_busy),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (rx_valid === 1'b1 && rx_ready) got.push_back(rx_data);
      if (rx_valid === 1'b1) valid_cycles++;
      if (rx_valid === 1'b1 && !valid_q) valid_rise = cyc;
      if (frame_err === 1'b1) begin
         ferr_cnt++;
         ferr_cyc = cyc;
      end
      if (overrun_err === 1'b1) ovr_cnt++;
      if (rx_busy === 1'b1 && !busy_q) busy_rise++;
      if (rx_busy === 1'b0 && busy_q) busy_fall++;
      valid_q = (rx_valid === 1'b1);
      busy_q  = (rx_busy === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic snap();
      b_got   = got.size();
      b_valid = valid_cycles;
      b_ferr  = ferr_cnt;
      b_ovr   = ovr_cnt;
      b_brise = busy_rise;
      b_bfall = busy_fall;
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (b_got + i < got.size()) ? 32'(got[b_got + i]) : 32'hDEAD;
   endfunction

   // One bit period; optional 1-cycle inversion at the mid-bit cycle.
   task automatic send_seg(input logic v, input bit glitch);
      rx = v;
      tick(HALF);
      if (glitch) rx = ~v;
      tick(1);
      rx = v;
      tick(CPB - HALF - 1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit glitch,
                             output int t0);
      t0 = cyc;
      send_seg(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_seg(d[i], glitch);
      send_seg(stop_v, glitch);
   endtask

   function automatic logic [31:0] lat_window(input int lat);
      return (lat >= 2223 && lat <= 2227) ? 32'd2225 : 32'(lat);
   endfunction

   initial begin
      int    t0;
      string msg;

      // Reset state
      tick(3);
      check("reset_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun_err}, 32'h0);
      sys_rst = 1'b0;
      tick(20);

      // 1: single byte, latency, 1-cycle valid
      snap();
      send_frame(8'h41, 1'b1, 1'b0, t0);
      tick(5);
      check("t1_count", got.size() - b_got, 1);
      check("t1_data", got_at(0), 32'h41);
      check("t1_latency", lat_window(valid_rise - t0), 2225);
      check("t1_valid_cycles", valid_cycles - b_valid, 1);
      check("t1_errors", (ferr_cnt - b_ferr) + (ovr_cnt - b_ovr), 0);

      // 2: 19 back-to-back bytes
      msg = "ABCD EFGH IJKL MNO\n";
      snap();
      for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1, 1'b0, t0);
      tick(5);
      check("t2_count", got.size() - b_got, 19);
      for (int i = 0; i < msg.len(); i++) check($sformatf("t2_byte%0d", i), got_at(i), 32'(msg[i]));
      check("t2_frame_err", ferr_cnt - b_ferr, 0);
      check("t2_overrun", ovr_cnt - b_ovr, 0);

      // 3: bad stop bit, then good frame
      snap();
      send_frame(8'h55, 1'b0, 1'b0, t0);
      rx = 1'b1;
      tick(5);
      check("t3_frame_err_cnt", ferr_cnt - b_ferr, 1);
      check("t3_frame_err_time", lat_window(ferr_cyc - t0), 2225);
      check("t3_no_valid", valid_cycles - b_valid, 0);
      check("t3_no_overrun", ovr_cnt - b_ovr, 0);
      tick(CPB);
      snap();
      send_frame(8'hAA, 1'b1, 1'b0, t0);
      tick(5);
      check("t3_aa_count", got.size() - b_got, 1);
      check("t3_aa_data", got_at(0), 32'hAA);

      // 4: short low glitch on an idle line
      snap();
      rx = 1'b0;
      tick(50);
      rx = 1'b1;
      tick(200);
      check("t4_busy_rise", busy_rise - b_brise, 1);
      check("t4_busy_fall", busy_fall - b_bfall, 1);
      check("t4_busy_now", rx_busy, 0);
      check("t4_no_valid", valid_cycles - b_valid, 0);
      check("t4_no_err", (ferr_cnt - b_ferr) + (ovr_cnt - b_ovr), 0);

      // 5: consumer stalled, second byte overruns
      snap();
      rx_ready = 1'b0;
      send_frame(8'h31, 1'b1, 1'b0, t0);
      send_frame(8'h32, 1'b1, 1'b0, t0);
      tick(5);
      check("t5_valid_held", rx_valid, 1);
      check("t5_data_held", rx_data, 32'h31);
      check("t5_overrun_cnt", ovr_cnt - b_ovr, 1);
      check("t5_no_frame_err", ferr_cnt - b_ferr, 0);
      rx_ready = 1'b1;
      tick(1);
      check("t5_valid_dropped", rx_valid, 0);
      tick(5);
      check("t5_presented_count", got.size() - b_got, 1);
      check("t5_presented_data", got_at(0), 32'h31);

      // 6: reset after data bit 3 of 0x7E, then a clean 0x7E
      send_seg(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_seg(1'(8'h7E >> i), 1'b0);
      rx = 1'b1;
      tick(50);
      check("t6_busy_before_reset", rx_busy, 1);
      sys_rst = 1'b1;
      tick(1);
      sys_rst = 1'b0;
      check("t6_reset_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun_err}, 32'h0);
      snap();
      tick(2 * CPB);
      check("t6_no_partial", valid_cycles - b_valid, 0);
      send_frame(8'h7E, 1'b1, 1'b0, t0);
      tick(5);
      check("t6_count", got.size() - b_got, 1);
      check("t6_data", got_at(0), 32'h7E);
      check("t6_no_err", (ferr_cnt - b_ferr) + (ovr_cnt - b_ovr), 0);

`ifdef UART_RX_MAJORITY_EN
      snap();
      send_frame(8'h7E, 1'b1, 1'b1, t0);
      tick(5);
      check("maj_glitch_count", got.size() - b_got, 1);
      check("maj_glitch_data", got_at(0), 32'h7E);
      check("maj_glitch_no_err", ferr_cnt - b_ferr, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
